// File: rtl/esp_fifo_bridge.sv
// esp_fifo_bridge: Z80 <-> ESP32 command-channel endpoint.
// Z80 side polls a status/ctrl register (F4) and a data register (F5); TX FIFO carries
// Z80 bytes plus start-of-frame markers toward the link, RX FIFO carries link bytes back.
// Optional feature: define ESP_LOOPBACK_EN to add a TX->RX loopback mode (ctrl bit6).
module esp_fifo_bridge #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       bus_sel,
    input  logic       bus_wr,
    input  logic       bus_rd,
    input  logic [7:0] bus_wrdata,
    output logic [7:0] bus_rddata,
    output logic [7:0] tx_data,
    output logic       tx_sof,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam int unsigned PtrW  = DEPTH_LOG2 + 1;

    logic [8:0]      tx_mem [Depth];
    logic [7:0]      rx_mem [Depth];
    logic [PtrW-1:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
    logic            overflow_q;
    logic [7:0]      rddata_q;
    logic            lb;

    logic            tx_empty, tx_full, rx_empty, rx_full;
    logic [8:0]      tx_head;
    logic [7:0]      rx_head;
    logic            start_frame, tx_push_req, tx_push, tx_drop, tx_pop;
    logic            lb_pop, lb_rx_push, link_acc, rx_push, rx_pop;
    logic [8:0]      tx_push_entry;
    logic [7:0]      rx_push_data;
    logic [7:0]      status;

`ifdef ESP_LOOPBACK_EN
    logic loopback_q;
    assign lb = loopback_q;
`else
    assign lb = 1'b0;
`endif

    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_full  = (tx_wptr_q[DEPTH_LOG2] != tx_rptr_q[DEPTH_LOG2]) &&
                      (tx_wptr_q[DEPTH_LOG2-1:0] == tx_rptr_q[DEPTH_LOG2-1:0]);
    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign rx_full  = (rx_wptr_q[DEPTH_LOG2] != rx_rptr_q[DEPTH_LOG2]) &&
                      (rx_wptr_q[DEPTH_LOG2-1:0] == rx_rptr_q[DEPTH_LOG2-1:0]);

    assign tx_head = tx_mem[tx_rptr_q[DEPTH_LOG2-1:0]];
    assign rx_head = rx_mem[rx_rptr_q[DEPTH_LOG2-1:0]];

    // Ctrl write with bit7 set: flush RX and queue a SOF marker
    assign start_frame   = bus_wr & ~bus_sel & bus_wrdata[7];
    assign tx_push_req   = (bus_wr & bus_sel) | start_frame;
    assign tx_push_entry = start_frame ? 9'h100 : {1'b0, bus_wrdata};

    // Loopback drains SOF markers unconditionally; data only when RX has room and no flush
    assign lb_pop     = lb & ~tx_empty & (tx_head[8] | (~rx_full & ~start_frame));
    assign lb_rx_push = lb_pop & ~tx_head[8];

    assign tx_valid = ~tx_empty & ~lb;
    assign tx_data  = tx_valid ? tx_head[7:0] : 8'h00;
    assign tx_sof   = tx_valid & tx_head[8];

    assign tx_pop  = (tx_valid & tx_ready) | lb_pop;
    // A pop in the same cycle frees the slot, so a push at full is still accepted
    assign tx_push = tx_push_req & (~tx_full | tx_pop);
    assign tx_drop = tx_push_req & ~tx_push;

    assign rx_ready     = ~rx_full & ~start_frame & ~lb;
    assign link_acc     = rx_valid & rx_ready;
    assign rx_push      = link_acc | lb_rx_push;
    assign rx_push_data = lb_rx_push ? tx_head[7:0] : rx_data;
    assign rx_pop       = bus_rd & bus_sel & ~rx_empty;

    assign status     = {1'b0, lb, 3'b000, overflow_q, tx_full, ~rx_empty};
    assign bus_rddata = rddata_q;

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wptr_q[DEPTH_LOG2-1:0]] <= tx_push_entry;
        end
        if (rx_push) begin
            rx_mem[rx_wptr_q[DEPTH_LOG2-1:0]] <= rx_push_data;
        end
    end

    // Pointers, sticky overflow, loopback mode and registered read data
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            overflow_q <= 1'b0;
            rddata_q   <= 8'h00;
`ifdef ESP_LOOPBACK_EN
            loopback_q <= 1'b0;
`endif
        end else begin
            if (tx_push) begin
                tx_wptr_q <= tx_wptr_q + PtrW'(1);
            end
            if (tx_pop) begin
                tx_rptr_q <= tx_rptr_q + PtrW'(1);
            end
            // rx_ready is low during start_frame, so no push races the flush
            if (rx_push) begin
                rx_wptr_q <= rx_wptr_q + PtrW'(1);
            end
            if (start_frame) begin
                rx_rptr_q <= rx_wptr_q;
            end else if (rx_pop) begin
                rx_rptr_q <= rx_rptr_q + PtrW'(1);
            end
            // Frame start clears overflow, but a dropped marker sets it again
            if (start_frame) begin
                overflow_q <= tx_drop;
            end else if (tx_drop) begin
                overflow_q <= 1'b1;
            end
`ifdef ESP_LOOPBACK_EN
            if (bus_wr && !bus_sel) begin
                loopback_q <= bus_wrdata[6];
            end
`endif
            if (bus_rd) begin
                if (bus_sel) begin
                    rddata_q <= rx_empty ? 8'h00 : rx_head;
                end else begin
                    rddata_q <= status;
                end
            end
        end
    end

endmodule

// File: tb/tb_esp_fifo_bridge.sv
// Self-checking bench for esp_fifo_bridge: directed scenarios followed by a randomized
// run, all checked against a queue-based reference model of the bridge behaviour.
module tb_esp_fifo_bridge;

    localparam int D = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       bus_sel, bus_wr, bus_rd;
    logic [7:0] bus_wrdata, bus_rddata;
    logic [7:0] tx_data;
    logic       tx_sof, tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;

    always #5 clk = ~clk;

    esp_fifo_bridge #(.DEPTH_LOG2(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus_sel    (bus_sel),
        .bus_wr     (bus_wr),
        .bus_rd     (bus_rd),
        .bus_wrdata (bus_wrdata),
        .bus_rddata (bus_rddata),
        .tx_data    (tx_data),
        .tx_sof     (tx_sof),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [8:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic       ovf_m = 1'b0;
    logic       lb_m  = 1'b0;
    logic [8:0] seen[$];
    logic       txv_seen = 1'b0;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic chk9(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] status_m();
        logic [7:0] s;
        s    = 8'h00;
        s[6] = lb_m;
        s[2] = ovf_m;
        s[1] = (tx_q.size() == D);
        s[0] = (rx_q.size() != 0);
        return s;
    endfunction

    // One clock: check link-side outputs mid-cycle, advance model, check read data after edge
    task automatic cycle();
        logic       sf, txv, rxr, txpop, lbpush, full0;
        logic [7:0] exp_rd;
        logic [8:0] head;
        @(negedge clk);
        sf  = bus_wr && !bus_sel && bus_wrdata[7];
        txv = (tx_q.size() != 0) && !lb_m;
        rxr = (rx_q.size() < D) && !sf && !lb_m;
        chk8("tx_valid", {7'b0, tx_valid}, {7'b0, txv});
        if (txv) chk9("tx_head", {tx_sof, tx_data}, tx_q[0]);
        chk8("rx_ready", {7'b0, rx_ready}, {7'b0, rxr});
        if (tx_valid) txv_seen = 1'b1;
        if (tx_valid && tx_ready) seen.push_back({tx_sof, tx_data});
        if (bus_sel) exp_rd = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        else         exp_rd = status_m();

        txpop  = txv && tx_ready;
        lbpush = 1'b0;
        head   = (tx_q.size() != 0) ? tx_q[0] : 9'h000;
        if (lb_m && tx_q.size() != 0) begin
            if (head[8]) txpop = 1'b1;
            else if (rx_q.size() < D && !sf) begin
                txpop  = 1'b1;
                lbpush = 1'b1;
            end
        end
        full0 = (tx_q.size() == D);
        if (txpop) void'(tx_q.pop_front());
        if (sf) ovf_m = 1'b0;
`ifdef ESP_LOOPBACK_EN
        if (bus_wr && !bus_sel) lb_m = bus_wrdata[6];
`endif
        if ((bus_wr && bus_sel) || sf) begin
            if (!full0 || txpop) tx_q.push_back(sf ? 9'h100 : {1'b0, bus_wrdata});
            else ovf_m = 1'b1;
        end
        if (sf) rx_q.delete();
        else begin
            if (bus_rd && bus_sel && rx_q.size() != 0) void'(rx_q.pop_front());
            if (rx_valid && rxr) rx_q.push_back(rx_data);
            if (lbpush) rx_q.push_back(head[7:0]);
        end

        @(posedge clk);
        #1;
        if (bus_rd) chk8("rddata", bus_rddata, exp_rd);
        bus_wr = 1'b0;
        bus_rd = 1'b0;
    endtask

    task automatic wr(input logic sel, input logic [7:0] d);
        bus_sel    = sel;
        bus_wrdata = d;
        bus_wr     = 1'b1;
        cycle();
    endtask

    task automatic rd(input logic sel);
        bus_sel = sel;
        bus_rd  = 1'b1;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic reset_dut();
        reset_n  = 1'b0;
        bus_wr   = 1'b0;
        bus_rd   = 1'b0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tx_q.delete();
        rx_q.delete();
        ovf_m = 1'b0;
        lb_m  = 1'b0;
        chk8("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        chk9("rst_tx_head", {tx_sof, tx_data}, 9'h000);
        chk8("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
        chk8("rst_rddata", bus_rddata, 8'h00);
    endtask

    initial begin
        logic [7:0] d;
        int         r;
        bus_sel    = 1'b0;
        bus_wrdata = 8'h00;
        rx_data    = 8'h00;

        // Reset
        reset_dut();
        rd(0);
        chk8("t1_status", bus_rddata, 8'h00);

        // Frame marker then two data bytes reach the link in order
        tx_ready = 1'b1;
        seen.delete();
        wr(0, 8'h80);
        wr(1, 8'h10);
        wr(1, 8'h2F);
        idle(3);
        chk8("t2_count", 8'(seen.size()), 8'd3);
        if (seen.size() == 3) begin
            chk9("t2_e0", seen[0], 9'h100);
            chk9("t2_e1", seen[1], 9'h010);
            chk9("t2_e2", seen[2], 9'h02F);
        end

        // Overfill TX: 17th byte dropped, overflow sticky
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) wr(1, 8'(8'h40 + i));
        rd(0);
        chk8("t3_status", bus_rddata, 8'h06);
        tx_ready = 1'b1;
        seen.delete();
        idle(18);
        chk8("t3_count", 8'(seen.size()), 8'd16);
        if (seen.size() == 16) chk9("t3_last", seen[15], 9'h04F);
        rd(0);
        chk8("t3_ovf_sticky", bus_rddata, 8'h04);
        wr(0, 8'h80);
        idle(2);

        // Link pushes two bytes; Z80 reads them back
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        cycle();
        rx_data  = 8'h5A;
        cycle();
        rx_valid = 1'b0;
        rd(0);
        chk8("t4_status", bus_rddata, 8'h01);
        rd(1);
        chk8("t4_rd0", bus_rddata, 8'hA5);
        rd(1);
        chk8("t4_rd1", bus_rddata, 8'h5A);
        rd(1);
        chk8("t4_rd_empty", bus_rddata, 8'h00);
        rd(0);
        chk8("t4_status_empty", bus_rddata, 8'h00);

        // Link byte offered during start-frame cycle is held off one cycle
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        bus_sel    = 1'b0;
        bus_wrdata = 8'h80;
        bus_wr     = 1'b1;
        #1;
        chk8("t5_rx_ready_sf", {7'b0, rx_ready}, 8'h00);
        cycle();
        cycle();
        rx_valid = 1'b0;
        idle(2);
        rd(0);
        chk8("t5_status", bus_rddata, 8'h01);
        rd(1);
        chk8("t5_rd", bus_rddata, 8'h77);
        rd(0);
        chk8("t5_status_after", bus_rddata, 8'h00);

`ifdef ESP_LOOPBACK_EN
        // Loopback: TX data returns through RX, link sees nothing
        tx_ready = 1'b1;
        txv_seen = 1'b0;
        wr(0, 8'hC0);
        wr(1, 8'h33);
        idle(3);
        rd(0);
        chk8("t6_status", bus_rddata, 8'h41);
        rd(1);
        chk8("t6_rd", bus_rddata, 8'h33);
        chk8("t6_no_tx_valid", {7'b0, txv_seen}, 8'h00);
        wr(0, 8'h00);
`endif

        // Randomized traffic with alternating fill/drain windows
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) reset_dut();
            if (((i / 256) % 2) == 0) tx_ready = ($urandom % 4 == 0);
            else                      tx_ready = ($urandom % 4 != 0);
            rx_valid = ($urandom % 2 == 0);
            rx_data  = 8'($urandom);
            r = int'($urandom % 8);
            d = 8'($urandom);
            case (r)
                0, 1: begin
                    bus_sel = 1'b1; bus_wrdata = d; bus_wr = 1'b1;
                end
                2: begin
                    if ($urandom % 6 != 0) d[7] = 1'b0;
                    bus_sel = 1'b0; bus_wrdata = d; bus_wr = 1'b1;
                end
                3, 4: begin
                    bus_sel = 1'b1;
                    bus_rd  = (((i / 256) % 2) == 1) || ($urandom % 4 == 0);
                end
                5: begin
                    bus_sel = 1'b0; bus_rd = 1'b1;
                end
                6: begin
                    if ($urandom % 6 != 0) d[7] = 1'b0;
                    bus_sel = 1'($urandom); bus_wrdata = d; bus_wr = 1'b1; bus_rd = 1'b1;
                end
                default: ;
            endcase
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
